// File: rtl/ram_line_sequencer.sv
// ram_line_sequencer: moves one cache line between the cache and a word-wide RAM, one word per handshake
module ram_line_sequencer #(
   parameter int ADDR_SIZE  = 14,
   parameter int WORD_SIZE  = 32,
   parameter int LINE_WIDTH = 128,
   parameter int TIMEOUT    = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      c_req,
   input  logic                      c_wr,
   input  logic [ADDR_SIZE-1:0]      c_addr,
   input  logic [LINE_WIDTH-1:0]     c_wdata,
   output logic                      c_ack,
   output logic                      c_err,
   output logic                      c_busy,
   output logic [LINE_WIDTH-1:0]     c_rdata,
   output logic                      ram_aval,
   output logic                      ram_wr,
   output logic [ADDR_SIZE+1:0]      ram_addr,
   output logic [WORD_SIZE-1:0]      ram_wdata,
   input  logic [WORD_SIZE-1:0]      ram_rdata,
   input  logic                      ram_ack
);
   localparam int WORDS = LINE_WIDTH / WORD_SIZE;
   localparam logic [7:0] TMO = 8'(TIMEOUT);
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
   state_t state, state_n;
   logic [ADDR_SIZE-1:0]  addr_q;
   logic                  wr_q;
   logic [LINE_WIDTH-1:0] wdata_q;
   logic [1:0]            k;
   logic [7:0]            cnt;
   logic                  err;
   logic                  last, expire;
   assign last   = k == 2'(WORDS - 1);
   assign expire = cnt + 8'd1 == TMO;
   // next-state selection and output decode from the current state
   always_comb begin
      state_n   = state == IDLE ? (c_req ? XFER : IDLE)
                : state == XFER ? (((ram_ack && last) || (!ram_ack && expire)) ? DONE : XFER)
                : IDLE;
      c_busy    = state != IDLE;
      c_ack     = state == DONE;
      c_err     = c_ack && err;
      ram_aval  = state == XFER;
      ram_wr    = ram_aval && wr_q;
      ram_addr  = ram_aval ? {addr_q, k} : '0;
      ram_wdata = ram_aval ? wdata_q[k*WORD_SIZE +: WORD_SIZE] : '0;
   end
   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end
   // request latch, word index, wait counter, error flag and refill assembly
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         k       <= '0;
         cnt     <= '0;
         err     <= 1'b0;
         c_rdata <= '0;
      end else if (state == IDLE && c_req) begin
         addr_q  <= c_addr;
         wr_q    <= c_wr;
         wdata_q <= c_wdata;
         k       <= '0;
         cnt     <= '0;
         err     <= 1'b0;
         if (!c_wr) c_rdata <= '0;
      end else if (state == XFER) begin
         if (ram_ack) begin
            if (!wr_q) c_rdata[k*WORD_SIZE +: WORD_SIZE] <= ram_rdata;
            k   <= k + 2'd1;
            cnt <= '0;
         end else if (expire) begin
            err <= 1'b1;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end
endmodule
